// File: rtl/cfu_cmd_sequencer.sv
// Matrix CFU command sequencer: loads A/B, runs, then reads C lanes back to memory.
// Define CFU_SEQ_CLEAR_C_EN to clear every C row before the loads.
module cfu_cmd_sequencer #(
    parameter int SRC_AW = 16,
    parameter int DST_AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [14:0]       a_words,
    input  logic [13:0]       b_words,
    input  logic [13:0]       c_rows,
    input  logic [SRC_AW-1:0] a_src_base,
    input  logic [SRC_AW-1:0] b_src_base,
    input  logic [DST_AW-1:0] dst_base,
    input  logic [8:0]        k,
    input  logic [8:0]        m,
    input  logic [8:0]        n,
    input  logic [8:0]        input_offset,
    output logic              busy,
    output logic              done,
    output logic              src_en,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [31:0]       src_rdata,
    output logic              dst_we,
    output logic [DST_AW-1:0] dst_addr,
    output logic [31:0]       dst_wdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [9:0]        cmd_payload_function_id,
    output logic [31:0]       cmd_payload_inputs_0,
    output logic [31:0]       cmd_payload_inputs_1,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [31:0]       rsp_payload_outputs_0
);
    // Phase encodings double as funct7 so function_id falls straight out of the register.
    typedef enum logic [2:0] {
        P_IDLE = 3'd0, P_LA = 3'd1, P_LB = 3'd2, P_RUN = 3'd3, P_RC = 3'd4, P_CLR = 3'd5
    } phase_t;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPT, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [14:0]       idx_q, idx_d, idx_nx;
    logic [1:0]        lane_q, lane_d;
    logic              latch, last;
    logic [14:0]       a_q;
    logic [13:0]       b_q, c_q;
    logic [SRC_AW-1:0] a_base_q, b_base_q;
    logic [DST_AW-1:0] dst_base_q;
    logic [8:0]        k_q, m_q, n_q, off_q;
    logic [31:0]       data_q;
    logic              dst_we_q, done_q;
    logic [DST_AW-1:0] dst_addr_q;
    logic [31:0]       dst_wdata_q;

    // Next non-empty phase after p; P_IDLE means the job is finished. RUN is never skipped.
    function automatic phase_t phase_after(phase_t p, logic [14:0] a, logic [13:0] b, logic [13:0] c);
        phase_t q;
        q = P_RUN;
        if (p == P_RUN) q = (c != '0) ? P_RC : P_IDLE;
        else if (p == P_RC) q = P_IDLE;
        else begin
            if (p != P_LB && b != '0) q = P_LB;
            if ((p == P_IDLE || p == P_CLR) && a != '0) q = P_LA;
`ifdef CFU_SEQ_CLEAR_C_EN
            if (p == P_IDLE && c != '0) q = P_CLR;
`endif
        end
        return q;
    endfunction

    function automatic state_t entry(phase_t p);
        state_t s;
        case (p)
            P_IDLE:      s = S_DONE;
            P_LA, P_LB:  s = S_FETCH;
            default:     s = S_ISSUE;
        endcase
        return s;
    endfunction

    assign idx_nx = idx_q + 15'd1;

    always_comb begin
        last = 1'b1;
        case (phase_q)
            P_LA:    last = (idx_nx == a_q);
            P_LB:    last = (idx_nx == {1'b0, b_q});
            P_RC:    last = (lane_q == 2'd3) && (idx_nx == {1'b0, c_q});
`ifdef CFU_SEQ_CLEAR_C_EN
            P_CLR:   last = (idx_nx == {1'b0, c_q});
`endif
            default: last = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                latch   = 1'b1;
                phase_d = phase_after(P_IDLE, a_words, b_words, c_rows);
                idx_d   = '0;
                lane_d  = '0;
                state_d = entry(phase_d);
            end
            S_FETCH: state_d = S_CAPT;
            S_CAPT:  state_d = S_ISSUE;
            S_ISSUE: if (cmd_ready) state_d = S_WAIT;
            S_WAIT: if (rsp_valid) begin
                if (last) begin
                    phase_d = phase_after(phase_q, a_q, b_q, c_q);
                    idx_d   = '0;
                    lane_d  = '0;
                    state_d = entry(phase_d);
                end else begin
                    if (phase_q == P_RC && lane_q != 2'd3) lane_d = lane_q + 2'd1;
                    else begin
                        idx_d  = idx_nx;
                        lane_d = '0;
                    end
                    state_d = entry(phase_q);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= P_IDLE;
            idx_q       <= '0;
            lane_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            dst_base_q  <= '0;
            k_q         <= '0;
            m_q         <= '0;
            n_q         <= '0;
            off_q       <= '0;
            data_q      <= '0;
            dst_we_q    <= 1'b0;
            dst_addr_q  <= '0;
            dst_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            if (latch) begin
                a_q        <= a_words;
                b_q        <= b_words;
                c_q        <= c_rows;
                a_base_q   <= a_src_base;
                b_base_q   <= b_src_base;
                dst_base_q <= dst_base;
                k_q        <= k;
                m_q        <= m;
                n_q        <= n;
                off_q      <= input_offset;
            end
            if (state_q == S_CAPT) data_q <= src_rdata;
            // Row r lane l lands at dst_base + 4r + l, i.e. {r,l} as an offset.
            dst_we_q <= (state_q == S_WAIT) && rsp_valid && (phase_q == P_RC);
            if ((state_q == S_WAIT) && rsp_valid && (phase_q == P_RC)) begin
                dst_addr_q  <= dst_base_q + DST_AW'({idx_q, lane_q});
                dst_wdata_q <= rsp_payload_outputs_0;
            end
            done_q <= (state_q == S_DONE);
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign src_en    = (state_q == S_FETCH);
    assign src_addr  = ((phase_q == P_LB) ? b_base_q : a_base_q) + SRC_AW'(idx_q);
    assign dst_we    = dst_we_q;
    assign dst_addr  = dst_addr_q;
    assign dst_wdata = dst_wdata_q;
    assign cmd_valid = (state_q == S_ISSUE);
    assign rsp_ready = (state_q == S_WAIT);
    assign cmd_payload_function_id = {4'b0, phase_q, 3'b0};

    always_comb begin
        cmd_payload_inputs_0 = '0;
        cmd_payload_inputs_1 = '0;
        case (phase_q)
            P_LA: begin
                cmd_payload_inputs_0 = {18'b0, idx_q[13:0]};
                cmd_payload_inputs_1 = data_q;
            end
            P_LB: begin
                cmd_payload_inputs_0 = {19'b0, idx_q[12:0]};
                cmd_payload_inputs_1 = data_q;
            end
            P_RUN: begin
                cmd_payload_inputs_0 = {5'b0, k_q, m_q, n_q};
                cmd_payload_inputs_1 = {23'b0, off_q};
            end
            P_RC: begin
                cmd_payload_inputs_0 = {19'b0, idx_q[12:0]};
                cmd_payload_inputs_1 = {30'b0, lane_q};
            end
            P_CLR:   cmd_payload_inputs_0 = {19'b0, idx_q[12:0]};
            default: cmd_payload_inputs_0 = '0;
        endcase
    end
endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// Scoreboard bench for cfu_cmd_sequencer: directed jobs, behavioural memories and CFU responder.
module tb_cfu_cmd_sequencer;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [14:0] a_words;
    logic [13:0] b_words, c_rows;
    logic [15:0] a_src_base, b_src_base, dst_base;
    logic [8:0]  k, m, n, input_offset;
    logic        busy, done, src_en, dst_we, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [15:0] src_addr, dst_addr;
    logic [31:0] src_rdata, dst_wdata, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_payload_outputs_0;
    logic [9:0]  cmd_payload_function_id;

    cfu_cmd_sequencer #(.SRC_AW(16), .DST_AW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .a_words(a_words), .b_words(b_words),
        .c_rows(c_rows), .a_src_base(a_src_base), .b_src_base(b_src_base), .dst_base(dst_base),
        .k(k), .m(m), .n(n), .input_offset(input_offset), .busy(busy), .done(done),
        .src_en(src_en), .src_addr(src_addr), .src_rdata(src_rdata), .dst_we(dst_we),
        .dst_addr(dst_addr), .dst_wdata(dst_wdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [9:0] fid; logic [31:0] in0; logic [31:0] in1;} cmd_t;
    typedef struct packed {logic [15:0] addr; logic [31:0] data;} wr_t;

`ifdef CFU_SEQ_CLEAR_C_EN
    localparam int CLR_CYC = 2;
`else
    localparam int CLR_CYC = 0;
`endif

    cmd_t        exp_cmd[$];
    wr_t         exp_wr[$];
    logic [31:0] smem [int];
    int checks = 0, fails = 0, cyc = 0;
    int src_en_cnt = 0, dst_we_cnt = 0, stall_left = 0, run_delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push_cmd(input logic [9:0] f, input logic [31:0] i0, input logic [31:0] i1);
        cmd_t c;
        c.fid = f; c.in0 = i0; c.in1 = i1;
        exp_cmd.push_back(c);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp_wr.push_back(w);
    endtask

    // Monitor: pops the scoreboards on every accepted command and destination write.
    initial begin
        cmd_t pc, c;
        wr_t  w;
        bit   prev_stall;
        prev_stall = 0;
        pc = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) prev_stall = 0;
            else begin
                if (src_en) src_en_cnt++;
                if (prev_stall)
                    check("stall_hold", 128'({cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}),
                          128'({1'b1, pc}));
                prev_stall = cmd_valid && !cmd_ready;
                pc = {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};
                if (cmd_valid && cmd_ready) begin
                    if (exp_cmd.size() == 0) check("cmd_unexpected", 128'(exp_cmd.size()), 128'(1));
                    else begin
                        c = exp_cmd.pop_front();
                        check("cmd", 128'({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}), 128'(c));
                    end
                end
                if (dst_we) begin
                    dst_we_cnt++;
                    if (exp_wr.size() == 0) check("dst_unexpected", 128'(exp_wr.size()), 128'(1));
                    else begin
                        w = exp_wr.pop_front();
                        check("dst_write", 128'({dst_addr, dst_wdata}), 128'(w));
                    end
                end
            end
        end
    end

    // Responder and source memory: sample mid-cycle, update just after the next edge.
    initial begin
        bit acc, rdn, sv, en, rst, pend;
        logic [15:0] sa;
        logic [9:0]  f;
        logic [31:0] i0, i1, ri0, ri1;
        int cnt;
        pend = 0; cnt = 0; ri0 = '0; ri1 = '0;
        cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_payload_outputs_0 = '0; src_rdata = '0;
        forever begin
            @(negedge clk);
            rst = reset; acc = cmd_valid && cmd_ready; rdn = rsp_valid && rsp_ready;
            sv = cmd_valid && !cmd_ready; en = src_en; sa = src_addr;
            f = cmd_payload_function_id; i0 = cmd_payload_inputs_0; i1 = cmd_payload_inputs_1;
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 0; rsp_valid = 1'b0; stall_left = 0; cmd_ready = 1'b1;
            end else begin
                if (rdn) rsp_valid = 1'b0;
                if (sv && stall_left > 0) stall_left--;
                if (acc) begin
                    pend = 1; ri0 = i0; ri1 = i1;
                    cnt = (f == 10'h018) ? run_delay : 0;
                end
                if (pend) begin
                    if (cnt == 0) begin
                        rsp_valid = 1'b1;
                        rsp_payload_outputs_0 = 32'hC0DE0000 ^ (ri0 << 4) ^ ri1;
                        pend = 0;
                    end else cnt--;
                end
                if (en) src_rdata = smem.exists(int'(sa)) ? smem[int'(sa)] : 32'hDEADBEEF;
                cmd_ready = (stall_left == 0);
            end
        end
    end

    task automatic set_ops(input logic [8:0] kk, input logic [8:0] mm, input logic [8:0] nn, input logic [8:0] off);
        a_src_base = 16'h0100; b_src_base = 16'h0200; dst_base = 16'h0040;
        k = kk; m = mm; n = nn; input_offset = off;
    endtask

    task automatic run_job(input string nm, input logic [14:0] a, input logic [13:0] b,
                           input logic [13:0] c, input int lat_exp, input bit restart);
        int t0, busy_low;
        bit seen;
        @(negedge clk);
        a_words = a; b_words = b; c_rows = c; start = 1'b1; t0 = cyc;
        seen = 0; busy_low = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            start = restart && (i == 4);
            if (restart && i == 4) begin
                a_words = 15'd5; b_words = 14'd0; c_rows = 14'd3; k = 9'd7; a_src_base = 16'h0300;
            end
            if (done) seen = 1;
            else if (!busy) busy_low++;
        end
        check({nm, "_done"}, 128'(seen), 128'(1));
        check({nm, "_latency"}, 128'(cyc - t0), 128'(lat_exp));
        check({nm, "_busy_held"}, 128'(busy_low), 128'(0));
        #2;
        check({nm, "_cmd_drained"}, 128'(exp_cmd.size()), 128'(0));
        check({nm, "_wr_drained"}, 128'(exp_wr.size()), 128'(0));
    endtask

    // Shared expectation for the a=2,b=1,c=1 job (k=1,m=2,n=3,offset=4).
    task automatic push_basic();
`ifdef CFU_SEQ_CLEAR_C_EN
        push_cmd(10'h028, 32'h0, 32'h0);
`endif
        push_cmd(10'h008, 32'h0, 32'h11223344);
        push_cmd(10'h008, 32'h1, 32'h55667788);
        push_cmd(10'h010, 32'h0, 32'hAABBCCDD);
        push_cmd(10'h018, 32'h00040403, 32'h4);
        for (int l = 0; l < 4; l++) begin
            push_cmd(10'h020, 32'h0, 32'(l));
            push_wr(16'h0040 + 16'(l), 32'hC0DE0000 | 32'(l));
        end
    endtask

    initial begin
        int se0, dw0, t;
        bit ok;
        reset = 1'b1; start = 1'b0; a_words = '0; b_words = '0; c_rows = '0;
        set_ops(9'd0, 9'd0, 9'd0, 9'd0);
        smem[32'h100] = 32'h11223344; smem[32'h101] = 32'h55667788;
        smem[32'h200] = 32'hAABBCCDD; smem[32'h201] = 32'h01020304; smem[32'h202] = 32'h05060708;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_ctrl", 128'({busy, done, src_en, dst_we, cmd_valid, rsp_ready}), 128'(0));
        check("reset_addr", 128'({src_addr, dst_addr, dst_wdata}), 128'(0));
        check("reset_payload", 128'({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}), 128'(0));

        // Basic job: 2 A loads, 1 B load, run, 4 reads.
        set_ops(9'd1, 9'd2, 9'd3, 9'd4);
        push_basic();
        run_job("basic", 15'd2, 14'd1, 14'd1, 24 + CLR_CYC, 1'b0);

        // cmd_ready withheld for 5 cycles on the single A load.
        set_ops(9'd1, 9'd2, 9'd3, 9'd4);
        push_cmd(10'h008, 32'h0, 32'h11223344);
        push_cmd(10'h018, 32'h00040403, 32'h4);
        stall_left = 5;
        run_job("stall", 15'd1, 14'd0, 14'd0, 13, 1'b0);

        // Run held off for 100 cycles by the responder.
        set_ops(9'd3, 9'd4, 9'd5, 9'd128);
        push_cmd(10'h018, 32'h000C0805, 32'h00000080);
        run_delay = 100;
        run_job("run_hold", 15'd0, 14'd0, 14'd0, 104, 1'b0);
        run_delay = 0;

        // Empty job: run only, no memory traffic.
        set_ops(9'd2, 9'd0, 9'd1, 9'd511);
        push_cmd(10'h018, 32'h00080001, 32'h000001FF);
        se0 = src_en_cnt; dw0 = dst_we_cnt;
        run_job("empty", 15'd0, 14'd0, 14'd0, 4, 1'b0);
        check("empty_src_en", 128'(src_en_cnt - se0), 128'(0));
        check("empty_dst_we", 128'(dst_we_cnt - dw0), 128'(0));

        // start re-pulsed mid-job with different inputs is ignored.
        set_ops(9'd1, 9'd2, 9'd3, 9'd4);
        push_basic();
        run_job("restart", 15'd2, 14'd1, 14'd1, 24 + CLR_CYC, 1'b1);

        // Reset while in LOAD_B, right after the first B command is accepted.
        set_ops(9'd1, 9'd2, 9'd3, 9'd4);
`ifdef CFU_SEQ_CLEAR_C_EN
        push_cmd(10'h028, 32'h0, 32'h0);
`endif
        push_cmd(10'h008, 32'h0, 32'h11223344);
        push_cmd(10'h010, 32'h0, 32'hAABBCCDD);
        @(negedge clk);
        a_words = 15'd1; b_words = 14'd3; c_rows = 14'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 0;
        for (t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            #2;
            if (exp_cmd.size() == 0) ok = 1;
        end
        check("reset_mid_reached", 128'(ok), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_busy", 128'(busy), 128'(0));
        check("reset_mid_cmd_valid", 128'(cmd_valid), 128'(0));
        check("reset_mid_rsp_ready", 128'(rsp_ready), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        exp_cmd.delete();

        // Block recovers cleanly after the mid-job reset.
        set_ops(9'd0, 9'd0, 9'd1, 9'd0);
        push_cmd(10'h018, 32'h00000001, 32'h0);
        run_job("after_reset", 15'd0, 14'd0, 14'd0, 4, 1'b0);

`ifdef CFU_SEQ_CLEAR_C_EN
        // Two clear commands precede the first load.
        set_ops(9'd1, 9'd2, 9'd3, 9'd4);
        push_cmd(10'h028, 32'h0, 32'h0);
        push_cmd(10'h028, 32'h1, 32'h0);
        push_cmd(10'h008, 32'h0, 32'h11223344);
        push_cmd(10'h018, 32'h00040403, 32'h4);
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < 4; l++) begin
                push_cmd(10'h020, 32'(r), 32'(l));
                push_wr(16'h0040 + 16'(4 * r + l), 32'hC0DE0000 ^ (32'(r) << 4) ^ 32'(l));
            end
        run_job("clear", 15'd1, 14'd0, 14'd2, 28, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
